hex_digit_sequencer: RTL

- Serialises a captured multi-digit hex value into a stream of 4-bit nibbles, MSB digit first, one per valid/ready handshake.
- Sits directly upstream of the hex-to-ASCII converter in the reaction_timer path. `o_hex` drives the converter's nibble input combinationally, and the resulting ASCII byte goes to the OLED text-draw stage, which supplies `i_ready`.
- Lets the timer display any N-digit value without the caller tracking digit positions.

---
 rtl/hex_digit_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/hex_digit_sequencer.sv
// Serialises a captured N-digit hex value into 4-bit nibbles, MSB digit first, one per valid/ready handshake.
// Optional leading-zero blanking: define HEX_SEQ_LEADING_ZERO_BLANK_EN.
module hex_digit_sequencer #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [4*N_DIGITS-1:0]   i_data,
  output logic                    o_busy,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [3:0]              o_hex,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_last,
  output logic                    o_blank,
  output logic                    o_done
);

  localparam int unsigned W = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             is_last;

  assign is_last = (idx_q == IDX_W'(N_DIGITS - 1));

`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
  logic nz_q, nz_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
      nz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
      nz_q    <= nz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
    nz_d    = nz_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          shreg_d = i_data;
          idx_d   = '0;
          state_d = SEND;
`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
          nz_d    = 1'b0;
`endif
        end
      end
      SEND: begin
        if (i_ready) begin
`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
          if (shreg_q[W-1 -: 4] != 4'h0) nz_d = 1'b1;
`endif
          // The last digit never shifts, so the index cannot wrap (matters for N_DIGITS=1).
          if (is_last) begin
            state_d = DONE;
          end else begin
            shreg_d = shreg_q << 4;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        shreg_d = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign o_valid     = (state_q == SEND);
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
  assign o_hex       = shreg_q[W-1 -: 4];
  assign o_digit_idx = idx_q;
  assign o_last      = o_valid && is_last;

`ifdef HEX_SEQ_LEADING_ZERO_BLANK_EN
  assign o_blank = o_valid && (o_hex == 4'h0) && !nz_q && !is_last;
`else
  assign o_blank = 1'b0;
`endif

endmodule
